// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time to a variable-latency imem, feeds IF/ID.
// Latency: a fetched word is presented to IF/ID in the same cycle imem_ready is seen (0 cycles).
// Backpressure: a stall with a returning word parks it in a one-entry skid buffer (S_HOLD). Optional IF_PERF_EN adds perf counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_plus4,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        ifid_en
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_ins_q, buf_ins_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;

    logic [31:0] pc_inc;
    logic        deliver;

    // Address arithmetic wraps naturally at 2^32.
    assign pc_inc  = pc_q + 32'd4;
    // A redirect in the completion cycle kills the returning word (it is wrong-path).
    assign deliver = (state_q == S_REQ) && imem_ready && !redirect;

    assign imem_addr = pc_q;
    assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
    assign ifid_en   = !stall;

    // Present the skid buffer, the live memory word, or a bubble to IF/ID.
    always_comb begin
        ins       = NOP_INSTR;
        pc_plus4  = 32'd0;
        ins_valid = 1'b0;
        if (state_q == S_HOLD) begin
            ins       = buf_ins_q;
            pc_plus4  = buf_pc4_q;
            ins_valid = 1'b1;
        end else if (deliver) begin
            ins       = imem_rdata;
            pc_plus4  = pc_inc;
            ins_valid = 1'b1;
        end
    end

    // Next-state logic; redirect outranks stall and imem_ready in every state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        buf_ins_d = buf_ins_q;
        buf_pc4_d = buf_pc4_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) pc_d = redirect_pc;
            end
            S_REQ: begin
                if (redirect) begin
                    if (imem_ready) begin
                        // Request just completed, so the new fetch can start immediately.
                        pc_d = redirect_pc;
                    end else begin
                        // Address must stay stable until the old request completes.
                        tgt_d   = redirect_pc;
                        state_d = S_DROP;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        buf_ins_d = imem_rdata;
                        buf_pc4_d = pc_inc;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = S_REQ;
                end else if (redirect) begin
                    tgt_d = redirect_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            tgt_q     <= 32'd0;
            buf_ins_q <= 32'd0;
            buf_pc4_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            buf_ins_q <= buf_ins_d;
            buf_pc4_q <= buf_pc4_d;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Count what IF/ID actually accepts: real instructions versus bubbles.
    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (ifid_en && ins_valid)  perf_fetch_d  = perf_fetch_q + 32'd1;
        if (ifid_en && !ins_valid) perf_bubble_d = perf_bubble_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, latency, stall/skid, redirect, wrap and optional perf counters.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later, well away from the edge.
// Observed outputs are packed as {imem_req, imem_addr, ins_valid, ins, pc_plus4, ifid_en}.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_plus4;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ifid_en;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_vec;
    int n_err;
    logic [98:0] obs;
    logic [98:0] exp_v;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc_plus4   (pc_plus4),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ifid_en    (ifid_en)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    assign obs = {imem_req, imem_addr, ins_valid, ins, pc_plus4, ifid_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        tick; tick;
        #1;
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
        // First cycle after release: still idle, a ready pulse must be ignored.
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0 ^ KEY;
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_release: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stream;
        logic [31:0] a;
        tick;
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * i);
            imem_ready = 1'b1; imem_rdata = a ^ KEY;
            #1;
            exp_v = {1'b1, a, 1'b1, a ^ KEY, a + 32'd4, 1'b1};
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL stream[%0d]: got %h want %h", i, obs, exp_v); end
            tick;
        end
    endtask

    task automatic test_latency;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 32'd16 + 32'(4 * k);
            for (int w = 0; w < 2; w++) begin
                imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
                #1;
                exp_v = {1'b1, a, 1'b0, 32'h0, 32'h0, 1'b1};
                n_vec++;
                if (obs !== exp_v) begin n_err++; $display("FAIL latency_wait[%0d,%0d]: got %h want %h", k, w, obs, exp_v); end
                tick;
            end
            imem_ready = 1'b1; imem_rdata = a ^ KEY;
            #1;
            exp_v = {1'b1, a, 1'b1, a ^ KEY, a + 32'd4, 1'b1};
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL latency_data[%0d]: got %h want %h", k, obs, exp_v); end
            tick;
        end
    endtask

    task automatic test_stall;
        // Redirect coinciding with completion: word dropped, new fetch at 8 next cycle.
        redirect = 1'b1; redirect_pc = 32'h8; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        exp_v = {1'b1, 32'd24, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL redirect_on_ready: got %h want %h", obs, exp_v); end
        tick;
        redirect = 1'b0; stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h8 ^ KEY;
        #1;
        exp_v = {1'b1, 32'h8, 1'b1, 32'h8 ^ KEY, 32'hC, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL stall_capture: got %h want %h", obs, exp_v); end
        tick;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_v = {1'b0, 32'hC, 1'b1, 32'h8 ^ KEY, 32'hC, 1'b0};
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", c, obs, exp_v); end
            tick;
        end
        stall = 1'b0;
        #1;
        exp_v = {1'b0, 32'hC, 1'b1, 32'h8 ^ KEY, 32'hC, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL stall_release: got %h want %h", obs, exp_v); end
        tick;
        exp_v = {1'b1, 32'hC, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL after_hold: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_redirect_drop;
        imem_ready = 1'b1; imem_rdata = 32'hC ^ KEY;
        #1;
        exp_v = {1'b1, 32'hC, 1'b1, 32'hC ^ KEY, 32'h10, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop_pre: got %h want %h", obs, exp_v); end
        tick;
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        exp_v = {1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop_redirect: got %h want %h", obs, exp_v); end
        tick;
        redirect = 1'b0;
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop_wait: got %h want %h", obs, exp_v); end
        tick;
        imem_ready = 1'b1; imem_rdata = 32'h10 ^ KEY;
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop_discard: got %h want %h", obs, exp_v); end
        tick;
        imem_ready = 1'b0;
        #1;
        exp_v = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop_target: got %h want %h", obs, exp_v); end
        // Two redirects while draining: the later target wins.
        redirect = 1'b1; redirect_pc = 32'h180;
        tick;
        redirect_pc = 32'h200;
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop2_stable: got %h want %h", obs, exp_v); end
        tick;
        redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h100 ^ KEY;
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop2_discard: got %h want %h", obs, exp_v); end
        tick;
        imem_ready = 1'b0;
        #1;
        exp_v = {1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop2_target: got %h want %h", obs, exp_v); end
        // Redirect in the very cycle the dropped request completes overrides tgt.
        redirect = 1'b1; redirect_pc = 32'h300;
        tick;
        redirect_pc = 32'h400; imem_ready = 1'b1; imem_rdata = 32'h200 ^ KEY;
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop3_discard: got %h want %h", obs, exp_v); end
        tick;
        redirect = 1'b0; imem_ready = 1'b0;
        #1;
        exp_v = {1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop3_target: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_redirect_stall;
        redirect = 1'b1; redirect_pc = 32'h500; stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h400 ^ KEY;
        #1;
        exp_v = {1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rs_same_cycle: got %h want %h", obs, exp_v); end
        tick;
        redirect = 1'b0; imem_ready = 1'b0;
        #1;
        exp_v = {1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rs_no_hold: got %h want %h", obs, exp_v); end
        stall = 1'b0;
    endtask

    task automatic test_hold_redirect;
        imem_ready = 1'b1; stall = 1'b1; imem_rdata = 32'h500 ^ KEY;
        tick;
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h600;
        #1;
        exp_v = {1'b0, 32'h504, 1'b1, 32'h500 ^ KEY, 32'h504, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hr_hold: got %h want %h", obs, exp_v); end
        tick;
        redirect = 1'b0; stall = 1'b0;
        #1;
        exp_v = {1'b1, 32'h600, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL hr_target: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick;
        redirect = 1'b0; imem_rdata = 32'hFFFF_FFFC ^ KEY;
        #1;
        exp_v = {1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC ^ KEY, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_data: got %h want %h", obs, exp_v); end
        tick;
        imem_ready = 1'b0;
        #1;
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_addr: got %h want %h", obs, exp_v); end
    endtask

`ifdef IF_PERF_EN
    task automatic test_perf;
        logic [8:0] rdy_pat;
        rdy_pat = 9'b1_0110_1011;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({perf_fetch_cnt, perf_bubble_cnt} !== 64'h0)
            begin n_err++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetch_cnt, perf_bubble_cnt); end
        // Idle cycle (bubble), then 9 fetch cycles with 6 completions.
        tick;
        for (int i = 0; i < 9; i++) begin
            imem_ready = rdy_pat[i]; imem_rdata = 32'h1234_0000;
            tick;
        end
        imem_ready = 1'b0;
        #1;
        n_vec++;
        if ({perf_fetch_cnt, perf_bubble_cnt} !== {32'd6, 32'd4})
            begin n_err++; $display("FAIL perf_counts: got %0d/%0d want 6/4", perf_fetch_cnt, perf_bubble_cnt); end
        rst = 1'b1;
        tick;
        n_vec++;
        if ({perf_fetch_cnt, perf_bubble_cnt} !== 64'h0)
            begin n_err++; $display("FAIL perf_clear: got %0d/%0d want 0/0", perf_fetch_cnt, perf_bubble_cnt); end
        rst = 1'b0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_stream;
        test_latency;
        test_stall;
        test_redirect_drop;
        test_redirect_stall;
        test_hold_redirect;
        test_wrap;
`ifdef IF_PERF_EN
        test_perf;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
